// File: rtl/tdc_sweep_if.sv
// ----------------------------------------------------------------------------
// tdc_sweep_if
// Control and result handshake bundle between the delay-sensor sweep
// sequencer and its requester/readout logic.
//   start, abort                   : sweep control from the requester
//   first_tap, last_tap, n_samples : sweep setup, captured on accepted start
//   res_valid/res_ready            : result handshake
//   res_tap, res_count             : result payload
//   busy, done                     : sequencer status
// master = requester/readout side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface tdc_sweep_if #(
    parameter int TAP_W = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [TAP_W-1:0] first_tap;
    logic [TAP_W-1:0] last_tap;
    logic [CNT_W-1:0] n_samples;
    logic             res_valid;
    logic             res_ready;
    logic [TAP_W-1:0] res_tap;
    logic [CNT_W-1:0] res_count;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, first_tap, last_tap, n_samples, res_ready,
        input  res_valid, res_tap, res_count, busy, done
    );

    modport slave (
        input  start, abort, first_tap, last_tap, n_samples, res_ready,
        output res_valid, res_tap, res_count, busy, done
    );
endinterface

// File: rtl/tdc_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tdc_sweep_ctrl
// Measurement sequencer for the inverter-chain delay sensor. On start it walks
// tap_sel from first_tap to last_tap; for each tap it waits SETTLE_CYC cycles,
// counts how many of n_samples synchronised sensor samples are high, and
// presents one {tap, count} result over a valid/ready handshake.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   sensor_in  : raw asynchronous sensor output (synchronised internally)
//   sensor_en  : enables the sensor chain (SETTLE and SAMPLE)
//   tap_sel    : registered tap select to the sensor mux
//   bus        : control, setup, result handshake and status (slave side)
// ----------------------------------------------------------------------------
module tdc_sweep_ctrl #(
    parameter int N_TAPS     = 16,
    parameter int TAP_W      = 4,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_in,
    output logic             sensor_en,
    output logic [TAP_W-1:0] tap_sel,
    tdc_sweep_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             w_done_nx;

    logic             r_sync1;
    logic             r_s_sync;
    logic [7:0]       r_settle_cnt;
    logic [CNT_W-1:0] r_samp_cnt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_nsamp;
    logic [TAP_W-1:0] r_tap;
    logic [TAP_W-1:0] r_last;
    logic             r_done;

    logic             w_settle_last;
    logic             w_samp_last;

    // Only matters when N_TAPS is not a power of two: tap codes past the
    // last implemented tap collapse onto it.
    function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] t);
        if ({1'b0, t} >= (TAP_W+1)'(N_TAPS))
            return TAP_W'(N_TAPS - 1);
        else
            return t;
    endfunction

    assign w_settle_last = (r_settle_cnt == 8'(SETTLE_CYC - 1));
    assign w_samp_last   = (r_samp_cnt == (r_nsamp - CNT_W'(1)));

    always_comb begin
        w_state_nx = r_state;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start)
                    w_state_nx = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_settle_last)
                    w_state_nx = (r_nsamp == '0) ? ST_REPORT : ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (w_samp_last)
                    w_state_nx = ST_REPORT;
            end
            ST_REPORT: begin
                if (bus.res_ready) begin
                    // Strict less-than keeps tap_sel from ever wrapping and
                    // makes a reversed range measure first_tap only.
                    if (r_tap < r_last) begin
                        w_state_nx = ST_SETTLE;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        // abort overrides start and any same-cycle handshake
        if (bus.abort) begin
            w_state_nx = ST_IDLE;
            w_done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_done       <= 1'b0;
            r_sync1      <= 1'b0;
            r_s_sync     <= 1'b0;
            r_settle_cnt <= '0;
            r_samp_cnt   <= '0;
            r_count      <= '0;
            r_nsamp      <= '0;
            r_tap        <= '0;
            r_last       <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_done   <= w_done_nx;
            r_sync1  <= sensor_in;
            r_s_sync <= r_sync1;

            // Counters restart whenever the state is left or re-entered.
            if (r_state == ST_SETTLE && w_state_nx == ST_SETTLE)
                r_settle_cnt <= r_settle_cnt + 8'd1;
            else
                r_settle_cnt <= '0;

            if (r_state == ST_SAMPLE && w_state_nx == ST_SAMPLE)
                r_samp_cnt <= r_samp_cnt + CNT_W'(1);
            else
                r_samp_cnt <= '0;

            // Held through REPORT until transfer, cleared everywhere else.
            if (r_state == ST_SAMPLE)
                r_count <= r_count + CNT_W'(r_s_sync);
            else if (r_state == ST_REPORT && w_state_nx == ST_REPORT)
                r_count <= r_count;
            else
                r_count <= '0;

            if (r_state == ST_IDLE && w_state_nx == ST_SETTLE) begin
                r_tap   <= clamp_tap(bus.first_tap);
                r_last  <= clamp_tap(bus.last_tap);
                r_nsamp <= bus.n_samples;
            end else if (r_state == ST_REPORT && w_state_nx == ST_SETTLE) begin
                r_tap <= r_tap + TAP_W'(1);
            end
        end
    end

    assign sensor_en     = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign tap_sel       = r_tap;
    assign bus.res_valid = (r_state == ST_REPORT);
    assign bus.res_tap   = r_tap;
    assign bus.res_count = r_count;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;

endmodule

// File: tb/tb_tdc_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tdc_sweep_ctrl
// Directed bench for tdc_sweep_ctrl with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_tdc_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sensor_en;
    logic [3:0] tap_sel;
    logic       sensor_in;
    logic       sens_lvl;
    logic       tog_en;
    logic       tog_q = 1'b0;

    int total = 0;
    int bad   = 0;

    tdc_sweep_if #(.TAP_W(4), .CNT_W(8)) bus ();

    tdc_sweep_ctrl #(
        .N_TAPS    (16),
        .TAP_W     (4),
        .SETTLE_CYC(4),
        .CNT_W     (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sensor_in(sensor_in),
        .sensor_en(sensor_en),
        .tap_sel  (tap_sel),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tog_q <= ~tog_q;
    assign sensor_in = tog_en ? tog_q : sens_lvl;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called in a cycle where the DUT is in SETTLE; n0 = cycles already
    // spent in SETTLE for this tap. Leaves the bench in the REPORT cycle.
    task automatic measure(input int tap, input int lo, input int hi,
                           input int lat, input int n0);
        int n;
        n = n0;
        while (!bus.res_valid && n < 200) begin
            tick();
            n++;
        end
        chk($sformatf("latency_t%0d", tap), n, lat);
        chk($sformatf("res_tap_t%0d", tap), bus.res_tap, tap);
        chk($sformatf("res_cnt_t%0d", tap),
            int'(bus.res_count >= 8'(lo) && bus.res_count <= 8'(hi)), 1);
    endtask

    task automatic go(input int f, input int l, input int n);
        bus.first_tap = 4'(f);
        bus.last_tap  = 4'(l);
        bus.n_samples = 8'(n);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    initial begin
        int  cnt0;
        logic seen;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.first_tap = '0;
        bus.last_tap  = '0;
        bus.n_samples = '0;
        bus.res_ready = 1'b0;
        sens_lvl      = 1'b0;
        tog_en        = 1'b0;
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_sens_en", sensor_en, 0);
        chk("rst_tap_sel", tap_sel, 0);
        chk("rst_done", bus.done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Constant high input, taps 3..5, 10 samples each.
        sens_lvl      = 1'b1;
        bus.res_ready = 1'b1;
        tick(); tick(); tick();
        go(3, 5, 10);
        chk("t1_busy", bus.busy, 1);
        chk("t1_tap_sel", tap_sel, 3);
        chk("t1_sens_en", sensor_en, 1);
        measure(3, 10, 10, 14, 0);
        for (int t = 4; t <= 5; t++) begin
            tick();
            chk("t1_tap_step", tap_sel, t);
            measure(t, 10, 10, 14, 0);
        end
        tick();
        chk("t1_done", bus.done, 1);
        chk("t1_idle", bus.busy, 0);
        tick();
        chk("t1_done_pulse", bus.done, 0);

        // Toggling input with backpressure.
        tog_en        = 1'b1;
        bus.res_ready = 1'b0;
        go(7, 7, 20);
        measure(7, 9, 11, 24, 0);
        cnt0 = int'(bus.res_count);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", bus.res_valid, 1);
            chk("t2_hold_tap", bus.res_tap, 7);
            chk("t2_hold_cnt", bus.res_count, cnt0);
        end
        bus.res_ready = 1'b1;
        tick();
        chk("t2_done", bus.done, 1);
        chk("t2_valid_drop", bus.res_valid, 0);
        chk("t2_idle", bus.busy, 0);
        tog_en = 1'b0;

        // Zero samples, reversed range.
        sens_lvl = 1'b1;
        go(9, 2, 0);
        measure(9, 0, 0, 4, 0);
        tick();
        chk("t3_done", bus.done, 1);
        chk("t3_idle", bus.busy, 0);

        // Ignored start, then abort in SETTLE of tap 1.
        sens_lvl = 1'b0;
        tick(); tick(); tick();
        go(0, 15, 4);
        go(9, 9, 0);
        chk("t4_start_ignored", tap_sel, 0);
        measure(0, 0, 0, 8, 1);
        tick();
        chk("t4_tap1", tap_sel, 1);
        chk("t4_settle", sensor_en, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t4_ab_busy", bus.busy, 0);
        chk("t4_ab_sens_en", sensor_en, 0);
        chk("t4_ab_valid", bus.res_valid, 0);
        chk("t4_ab_done", bus.done, 0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen = seen | bus.res_valid | bus.done | bus.busy;
        end
        chk("t4_quiet", seen, 0);

        // Full range, 1 sample per tap.
        sens_lvl = 1'b1;
        tick(); tick(); tick();
        go(0, 15, 1);
        measure(0, 1, 1, 5, 0);
        for (int t = 1; t <= 15; t++) begin
            tick();
            chk("t5_tap_step", tap_sel, t);
            measure(t, 1, 1, 5, 0);
        end
        tick();
        chk("t5_done", bus.done, 1);
        chk("t5_tap_end", tap_sel, 15);
        tick(); tick(); tick();
        chk("t5_no_wrap", tap_sel, 15);
        chk("t5_idle", bus.busy, 0);

        // Reset asserted while sampling.
        go(3, 5, 10);
        repeat (6) tick();
        chk("t6_in_sample", sensor_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", bus.busy, 0);
        chk("t6_sens_en", sensor_en, 0);
        chk("t6_valid", bus.res_valid, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_tap_sel", tap_sel, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_post_busy", bus.busy, 0);
        chk("t6_post_tap", tap_sel, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
